// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - three-requester arbiter in front of a single-port memory
// Requester 0 (VGA) has absolute priority; requesters 1 and 2 share a round-robin pointer.
module memory_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [2:0]              req_i,
   input  logic [2:0]              we_i,
   input  logic [3*ADDR_WIDTH-1:0] addr_i,
   input  logic [3*DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic [2:0]              ack_o,
   output logic                    err_o,
   output logic                    mem_req_o,
   output logic                    mem_we_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
   input  logic                    mem_ack_i
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [2:0]            r_gnt;
   logic                  r_rr;
   logic [15:0]           r_cnt;
   logic                  r_mem_req;
   logic                  r_mem_we;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [2:0]            r_ack;
   logic                  r_err;

   logic [2:0]            w_sel;
   logic                  w_sel_we;
   logic [ADDR_WIDTH-1:0] w_sel_addr;
   logic [DATA_WIDTH-1:0] w_sel_wdata;
   logic                  w_to_hit;

   logic [2:0]            w_gnt_nxt;
   logic                  w_rr_nxt;
   logic [15:0]           w_cnt_nxt;
   logic                  w_mem_req_nxt;
   logic                  w_mem_we_nxt;
   logic [ADDR_WIDTH-1:0] w_mem_addr_nxt;
   logic [DATA_WIDTH-1:0] w_mem_wdata_nxt;
   logic [DATA_WIDTH-1:0] w_rdata_nxt;
   logic [2:0]            w_ack_nxt;
   logic                  w_err_nxt;

   // r_rr == 0 favours requester 1 when both 1 and 2 are requesting
   always_comb begin
      w_sel = 3'b000;
      if (req_i[0])
         w_sel = 3'b001;
      else if (req_i[1] && req_i[2])
         w_sel = r_rr ? 3'b100 : 3'b010;
      else if (req_i[1])
         w_sel = 3'b010;
      else if (req_i[2])
         w_sel = 3'b100;
   end

   always_comb begin
      w_sel_we    = we_i[0];
      w_sel_addr  = addr_i[0 +: ADDR_WIDTH];
      w_sel_wdata = wdata_i[0 +: DATA_WIDTH];
      if (w_sel[1]) begin
         w_sel_we    = we_i[1];
         w_sel_addr  = addr_i[ADDR_WIDTH +: ADDR_WIDTH];
         w_sel_wdata = wdata_i[DATA_WIDTH +: DATA_WIDTH];
      end else if (w_sel[2]) begin
         w_sel_we    = we_i[2];
         w_sel_addr  = addr_i[2*ADDR_WIDTH +: ADDR_WIDTH];
         w_sel_wdata = wdata_i[2*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign w_to_hit = (r_cnt == LP_CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (|req_i) w_state_nxt = S_BUSY;
         S_BUSY:  if (mem_ack_i || w_to_hit) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_gnt_nxt       = r_gnt;
      w_rr_nxt        = r_rr;
      w_cnt_nxt       = r_cnt;
      w_mem_req_nxt   = r_mem_req;
      w_mem_we_nxt    = r_mem_we;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      w_rdata_nxt     = r_rdata;
      w_ack_nxt       = 3'b000;
      w_err_nxt       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = 16'd0;
            if (|req_i) begin
               w_gnt_nxt       = w_sel;
               w_mem_req_nxt   = 1'b1;
               w_mem_we_nxt    = w_sel_we;
               w_mem_addr_nxt  = w_sel_addr;
               w_mem_wdata_nxt = w_sel_wdata;
               if (!w_sel[0])
                  w_rr_nxt = ~r_rr;
            end
         end
         S_BUSY: begin
            // a late ack landing on the final count still completes normally
            if (mem_ack_i) begin
               w_mem_req_nxt = 1'b0;
               w_ack_nxt     = r_gnt;
               w_rdata_nxt   = mem_rdata_i;
            end else if (w_to_hit) begin
               w_mem_req_nxt = 1'b0;
               w_ack_nxt     = r_gnt;
               w_err_nxt     = 1'b1;
               w_rdata_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 16'd1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gnt       <= 3'b000;
         r_rr        <= 1'b0;
         r_cnt       <= 16'd0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_rdata     <= '0;
         r_ack       <= 3'b000;
         r_err       <= 1'b0;
      end else begin
         r_gnt       <= w_gnt_nxt;
         r_rr        <= w_rr_nxt;
         r_cnt       <= w_cnt_nxt;
         r_mem_req   <= w_mem_req_nxt;
         r_mem_we    <= w_mem_we_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_rdata     <= w_rdata_nxt;
         r_ack       <= w_ack_nxt;
         r_err       <= w_err_nxt;
      end
   end

   assign rdata_o     = r_rdata;
   assign ack_o       = r_ack;
   assign err_o       = r_err;
   assign mem_req_o   = r_mem_req;
   assign mem_we_o    = r_mem_we;
   assign mem_addr_o  = r_mem_addr;
   assign mem_wdata_o = r_mem_wdata;

endmodule
